dma_transfer_fsm: RTL and testbench

DMA_TRANSFER_FSM -- requirements
Module: dma_transfer_fsm

---
 rtl/dma_transfer_fsm.sv | 177 +++++++++++++++++
 tb/tb_dma_transfer_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_transfer_fsm.sv
// Four-channel single-transfer DMA sequencer (IDLE, S0..S4) with per-channel address/count registers.
// Optional macro DMA_AUTOINIT_EN: at terminal count a channel reloads from base instead of masking itself.
module dma_transfer_fsm #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        DREQ,
  input  logic              HLDA,
  input  logic [3:0]        DACK,
  input  logic              EOP_N_IN,
  input  logic              cfgWe,
  input  logic [1:0]        cfgCh,
  input  logic [1:0]        cfgMode,
  input  logic [ADDR_W-1:0] cfgAddr,
  input  logic [CNT_W-1:0]  cfgCount,
  output logic              HRQ,
  output logic              assertDACK,
  output logic              AEN,
  output logic [ADDR_W-1:0] ADDR,
  output logic              MEMR_N,
  output logic              MEMW_N,
  output logic              IOR_N,
  output logic              IOW_N,
  output logic              EOP_N_OUT,
  output logic [3:0]        tcStatus
);

  // state | meaning
  // IDLE  | bus released, waiting for an unmasked request
  // S0    | hold requested, waiting for HLDA
  // S1    | DACK enabled, grant latched at end of cycle
  // S2    | read strobe low
  // S3    | read and write strobes low
  // S4    | strobes released, address/count update, terminal count
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S0   = 3'd1;
  localparam logic [2:0] S1   = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] S3   = 3'd4;
  localparam logic [2:0] S4   = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [1:0]        r_ch;
  logic              r_eop;
  logic [ADDR_W-1:0] r_base_addr [4];
  logic [ADDR_W-1:0] r_cur_addr  [4];
  logic [CNT_W-1:0]  r_base_cnt  [4];
  logic [CNT_W-1:0]  r_cur_cnt   [4];
  logic [1:0]        r_mode      [4];
  logic [3:0]        r_mask;
  logic [3:0]        r_tc;

  logic [1:0] w_dack_ch;
  logic       w_dack_ok;
  logic       w_req;
  logic       w_cfg_hit;
  logic       w_tc;
  logic       w_active;
  logic       w_rd;
  logic       w_wr;

  always_comb begin
    w_dack_ch = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (DACK[i]) w_dack_ch = 2'(i);
    end
  end

  assign w_dack_ok = $onehot(DACK) && !r_mask[w_dack_ch];
  assign w_req     = |(DREQ & ~r_mask);
  assign w_cfg_hit = cfgWe && (cfgCh == r_ch);
  // A same-cycle reprogram of the active channel suppresses its terminal count.
  assign w_tc      = (r_state == S4) && ((r_cur_cnt[r_ch] == '0) || r_eop) && !w_cfg_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_next = S0;
      S0: begin
        if (HLDA)        w_next = S1;
        else if (!w_req) w_next = IDLE;
      end
      S1:      w_next = (HLDA && w_dack_ok) ? S2 : IDLE;
      S2:      w_next = HLDA ? S3 : IDLE;
      S3:      w_next = HLDA ? S4 : IDLE;
      S4:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ch    <= 2'd0;
      r_eop   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S1) begin
        r_ch  <= w_dack_ch;
        r_eop <= 1'b0;
      end
      if ((r_state == S2 || r_state == S3) && !EOP_N_IN) r_eop <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        r_base_addr[i] <= '0;
        r_cur_addr[i]  <= '0;
        r_base_cnt[i]  <= '0;
        r_cur_cnt[i]   <= '0;
        r_mode[i]      <= 2'b00;
      end
      r_mask <= 4'hF;
      r_tc   <= 4'h0;
    end else begin
      if (r_state == S4 && !w_cfg_hit) begin
`ifdef DMA_AUTOINIT_EN
        if (w_tc) begin
          r_cur_addr[r_ch] <= r_base_addr[r_ch];
          r_cur_cnt[r_ch]  <= r_base_cnt[r_ch];
        end else begin
          r_cur_addr[r_ch] <= r_cur_addr[r_ch] + ADDR_ONE;
          r_cur_cnt[r_ch]  <= r_cur_cnt[r_ch] - CNT_ONE;
        end
`else
        r_cur_addr[r_ch] <= r_cur_addr[r_ch] + ADDR_ONE;
        r_cur_cnt[r_ch]  <= r_cur_cnt[r_ch] - CNT_ONE;
        if (w_tc) r_mask[r_ch] <= 1'b1;
`endif
        if (w_tc) r_tc[r_ch] <= 1'b1;
      end
      if (cfgWe) begin
        r_base_addr[cfgCh] <= cfgAddr;
        r_cur_addr[cfgCh]  <= cfgAddr;
        r_base_cnt[cfgCh]  <= cfgCount;
        r_cur_cnt[cfgCh]   <= cfgCount;
        r_mode[cfgCh]      <= cfgMode;
        r_mask[cfgCh]      <= 1'b0;
        r_tc[cfgCh]        <= 1'b0;
      end
    end
  end

  assign w_active   = (r_state == S1) || (r_state == S2) || (r_state == S3) || (r_state == S4);
  assign w_rd       = (r_state == S2) || (r_state == S3);
  assign w_wr       = (r_state == S3);

  assign HRQ        = (r_state != IDLE);
  assign assertDACK = w_active;
  assign AEN        = w_active;

  // In S1 the channel is not yet latched, so the address follows the live grant.
  always_comb begin
    ADDR = '0;
    if (r_state == S1) begin
      if (w_dack_ok) ADDR = r_cur_addr[w_dack_ch];
    end else if (w_active) begin
      ADDR = r_cur_addr[r_ch];
    end
  end

  assign IOR_N     = !(w_rd && r_mode[r_ch] == 2'b01);
  assign MEMW_N    = !(w_wr && r_mode[r_ch] == 2'b01);
  assign MEMR_N    = !(w_rd && r_mode[r_ch] == 2'b10);
  assign IOW_N     = !(w_wr && r_mode[r_ch] == 2'b10);
  assign EOP_N_OUT = !w_tc;
  assign tcStatus  = r_tc;

endmodule

// File: tb/tb_dma_transfer_fsm.sv
// Self-checking bench for dma_transfer_fsm: per-cycle transfer-phase model plus directed scenarios.
// Honours DMA_AUTOINIT_EN when the design is built with it.
module tb_dma_transfer_fsm;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  DREQ;
  logic        HLDA;
  logic [3:0]  DACK;
  logic        EOP_N_IN;
  logic        cfgWe;
  logic [1:0]  cfgCh;
  logic [1:0]  cfgMode;
  logic [15:0] cfgAddr;
  logic [15:0] cfgCount;
  logic        HRQ, assertDACK, AEN;
  logic [15:0] ADDR;
  logic        MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT;
  logic [3:0]  tcStatus;

  dma_transfer_fsm #(.ADDR_W(16), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .DACK(DACK), .EOP_N_IN(EOP_N_IN),
    .cfgWe(cfgWe), .cfgCh(cfgCh), .cfgMode(cfgMode), .cfgAddr(cfgAddr), .cfgCount(cfgCount),
    .HRQ(HRQ), .assertDACK(assertDACK), .AEN(AEN), .ADDR(ADDR),
    .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N_OUT(EOP_N_OUT), .tcStatus(tcStatus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Priority logic stand-in: grants the selected channel whenever DACK generation is enabled.
  logic [3:0] grant;
  assign DACK = assertDACK ? grant : 4'b0000;

  // CPU stand-in: acknowledges hold requests, unless the scenario drives HLDA itself.
  logic hlda_auto;
  always begin
    @(posedge CLK);
    #2;
    if (hlda_auto) HLDA = HRQ;
  end

  // Model: phase 0 idle, 1 hold request, 2 grant, 3 read, 4 read+write, 5 finish.
  int          m_ph;
  int          m_ch;
  logic        m_eop;
  logic [15:0] m_addr [4];
  logic [15:0] m_cnt  [4];
  logic [15:0] m_baddr[4];
  logic [15:0] m_bcnt [4];
  logic [1:0]  m_mode [4];
  logic [3:0]  m_mask;
  logic [3:0]  m_tc;
  int          m_next;
  logic        m_tcev;

  function automatic int idx_of(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic any_req(input logic [3:0] req, input logic [3:0] mask);
    return |(req & ~mask);
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_ph = 0; m_ch = 0; m_eop = 1'b0; m_mask = 4'hF; m_tc = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_addr[i] = '0; m_cnt[i] = '0; m_baddr[i] = '0; m_bcnt[i] = '0; m_mode[i] = 2'b00;
      end
    end else begin
      m_next = m_ph;
      case (m_ph)
        0: if (any_req(DREQ, m_mask)) m_next = 1;
        1: if (HLDA) m_next = 2; else if (!any_req(DREQ, m_mask)) m_next = 0;
        2: begin
          if (HLDA && $countones(DACK) == 1 && !m_mask[idx_of(DACK)]) begin
            m_ch = idx_of(DACK); m_eop = 1'b0; m_next = 3;
          end else m_next = 0;
        end
        3, 4: begin
          if (!EOP_N_IN) m_eop = 1'b1;
          m_next = HLDA ? m_ph + 1 : 0;
        end
        5: begin
          m_next = 0;
          if (!(cfgWe && cfgCh == 2'(m_ch))) begin
            m_tcev = (m_cnt[m_ch] == 16'h0) || m_eop;
            m_addr[m_ch] = m_addr[m_ch] + 16'd1;
            m_cnt[m_ch]  = m_cnt[m_ch] - 16'd1;
            if (m_tcev) begin
              m_tc[m_ch] = 1'b1;
`ifdef DMA_AUTOINIT_EN
              m_addr[m_ch] = m_baddr[m_ch];
              m_cnt[m_ch]  = m_bcnt[m_ch];
`else
              m_mask[m_ch] = 1'b1;
`endif
            end
          end
        end
        default: m_next = 0;
      endcase
      if (cfgWe) begin
        m_addr[cfgCh] = cfgAddr; m_baddr[cfgCh] = cfgAddr;
        m_cnt[cfgCh] = cfgCount; m_bcnt[cfgCh] = cfgCount;
        m_mode[cfgCh] = cfgMode; m_mask[cfgCh] = 1'b0; m_tc[cfgCh] = 1'b0;
      end
      m_ph = m_next;
    end
  end

  logic [15:0] e_addr;
  logic        e_rd, e_wr, e_eop;
  always @(negedge CLK) begin
    e_rd  = (m_ph == 3) || (m_ph == 4);
    e_wr  = (m_ph == 4);
    e_addr = 16'h0;
    if (m_ph >= 3) e_addr = m_addr[m_ch];
    else if (m_ph == 2 && $countones(DACK) == 1 && !m_mask[idx_of(DACK)]) e_addr = m_addr[idx_of(DACK)];
    e_eop = (m_ph == 5) && ((m_cnt[m_ch] == 16'h0) || m_eop) && !(cfgWe && cfgCh == 2'(m_ch));
    chk("HRQ", 32'(HRQ), 32'(m_ph != 0));
    chk("AEN", 32'(AEN), 32'(m_ph >= 2));
    chk("assertDACK", 32'(assertDACK), 32'(m_ph >= 2));
    chk("ADDR", 32'(ADDR), 32'(e_addr));
    chk("IOR_N", 32'(IOR_N), 32'(!(e_rd && m_mode[m_ch] == 2'b01)));
    chk("MEMW_N", 32'(MEMW_N), 32'(!(e_wr && m_mode[m_ch] == 2'b01)));
    chk("MEMR_N", 32'(MEMR_N), 32'(!(e_rd && m_mode[m_ch] == 2'b10)));
    chk("IOW_N", 32'(IOW_N), 32'(!(e_wr && m_mode[m_ch] == 2'b10)));
    chk("EOP_N_OUT", 32'(EOP_N_OUT), 32'(!e_eop));
    chk("tcStatus", 32'(tcStatus), 32'(m_tc));
  end

  // Bus activity recorder for the hand-computed scenario checks.
  logic [15:0] cap_q[$];
  int eop_cnt, hrq_cnt, memr_cnt, memw_cnt, ior_cnt, iow_cnt;
  always @(negedge CLK) begin
    if (!MEMW_N || !IOW_N) cap_q.push_back(ADDR);
    if (!EOP_N_OUT) eop_cnt++;
    if (HRQ)        hrq_cnt++;
    if (!MEMR_N)    memr_cnt++;
    if (!MEMW_N)    memw_cnt++;
    if (!IOR_N)     ior_cnt++;
    if (!IOW_N)     iow_cnt++;
  end

  function automatic logic [31:0] capv(input int i);
    return (cap_q.size() > i) ? 32'(cap_q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic prog(input logic [1:0] ch, input logic [1:0] md, input logic [15:0] a, input logic [15:0] c);
    cfgWe = 1'b1; cfgCh = ch; cfgMode = md; cfgAddr = a; cfgCount = c;
    tick();
    cfgWe = 1'b0;
  endtask

  task automatic clr();
    cap_q.delete();
    eop_cnt = 0; hrq_cnt = 0; memr_cnt = 0; memw_cnt = 0; ior_cnt = 0; iow_cnt = 0;
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'h0; HLDA = 1'b0; EOP_N_IN = 1'b1; hlda_auto = 1'b1;
    cfgWe = 1'b0; cfgCh = 2'd0; cfgMode = 2'b00; cfgAddr = 16'h0; cfgCount = 16'h0; grant = 4'h0;
    clr();
    @(negedge CLK); #1;
    chk("reset HRQ", 32'(HRQ), 32'd0);
    chk("reset ADDR", 32'(ADDR), 32'd0);
    chk("reset strobes", 32'({MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT}), 32'h1F);
    chk("reset tcStatus", 32'(tcStatus), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // Channel 0: IO->memory, count 2 gives three words then terminal count.
    prog(2'd0, 2'b01, 16'h1000, 16'h0002);
    clr(); grant = 4'b0001; DREQ = 4'b0001;
    for (int k = 0; k < 60 && EOP_N_OUT; k++) begin @(negedge CLK); #1; end
    chk("ch0 tc reached", 32'(EOP_N_OUT), 32'd0);
    DREQ = 4'h0;
    run(4);
    chk("ch0 transfers", 32'(cap_q.size()), 32'd3);
    chk("ch0 addr0", capv(0), 32'h1000);
    chk("ch0 addr1", capv(1), 32'h1001);
    chk("ch0 addr2", capv(2), 32'h1002);
    chk("ch0 eop pulses", 32'(eop_cnt), 32'd1);
    chk("ch0 ior cycles", 32'(ior_cnt), 32'd6);
    chk("ch0 memw cycles", 32'(memw_cnt), 32'd3);
    chk("ch0 tcStatus", 32'(tcStatus), 32'h1);

    clr(); DREQ = 4'b0001;
    run(14);
    DREQ = 4'h0;
    run(8);
`ifdef DMA_AUTOINIT_EN
    chk("autoinit restart addr", capv(0), 32'h1000);
`else
    chk("masked after tc HRQ", 32'(hrq_cnt), 32'd0);
    chk("masked after tc xfers", 32'(cap_q.size()), 32'd0);
`endif

    // Channel 2: memory->IO across the address wrap.
    prog(2'd2, 2'b10, 16'hFFFF, 16'd5);
    clr(); grant = 4'b0100; DREQ = 4'b0100;
    for (int k = 0; k < 60 && cap_q.size() < 2; k++) begin @(negedge CLK); #1; end
    chk("ch2 two xfers", 32'(cap_q.size() >= 2), 32'd1);
    DREQ = 4'h0;
    run(4);
    chk("wrap addr0", capv(0), 32'hFFFF);
    chk("wrap addr1", capv(1), 32'h0000);
    chk("ch2 memr cycles", 32'(memr_cnt), 32'd4);
    chk("ch2 iow cycles", 32'(iow_cnt), 32'd2);
    chk("ch2 ior cycles", 32'(ior_cnt), 32'd0);

    // Channel 3: HLDA withdrawn during the read phase aborts without an update.
    prog(2'd3, 2'b01, 16'h2000, 16'd3);
    clr(); grant = 4'b1000; DREQ = 4'b1000;
    for (int k = 0; k < 60 && IOR_N; k++) begin @(negedge CLK); #1; end
    chk("ch3 read phase", 32'(IOR_N), 32'd0);
    hlda_auto = 1'b0; HLDA = 1'b0; DREQ = 4'h0;
    @(negedge CLK); #1;
    chk("abort strobes", 32'({MEMR_N, MEMW_N, IOR_N, IOW_N}), 32'hF);
    chk("abort HRQ", 32'(HRQ), 32'd0);
    chk("abort no write", 32'(cap_q.size()), 32'd0);
    hlda_auto = 1'b1; DREQ = 4'b1000;
    for (int k = 0; k < 60 && cap_q.size() < 1; k++) begin @(negedge CLK); #1; end
    DREQ = 4'h0;
    run(4);
    chk("abort addr kept", capv(0), 32'h2000);

    // Channel 1: external EOP during S3 forces terminal count with count far from zero.
    prog(2'd1, 2'b10, 16'h3000, 16'h0010);
    clr(); grant = 4'b0010; DREQ = 4'b0010;
    for (int k = 0; k < 60 && IOW_N; k++) begin @(negedge CLK); #1; end
    chk("ch1 write phase", 32'(IOW_N), 32'd0);
    EOP_N_IN = 1'b0; DREQ = 4'h0;
    @(negedge CLK); #1;
    chk("ext eop pulse", 32'(EOP_N_OUT), 32'd0);
    tick();
    EOP_N_IN = 1'b1;
    chk("ext eop tcStatus", 32'(tcStatus), 32'h3);

    // Channel 3: reprogramming during S4 wins over the terminal count.
    prog(2'd3, 2'b01, 16'h4000, 16'h0000);
    clr(); grant = 4'b1000; DREQ = 4'b1000;
    for (int k = 0; k < 60 && MEMW_N; k++) begin @(negedge CLK); #1; end
    chk("ch3 write phase", 32'(MEMW_N), 32'd0);
    tick();
    cfgWe = 1'b1; cfgCh = 2'd3; cfgMode = 2'b01; cfgAddr = 16'h5000; cfgCount = 16'h0001; DREQ = 4'h0;
    @(negedge CLK); #1;
    chk("cfg wins no eop", 32'(EOP_N_OUT), 32'd1);
    tick();
    cfgWe = 1'b0;
    chk("cfg wins tcStatus", 32'(tcStatus), 32'h3);
    clr(); DREQ = 4'b1000;
    for (int k = 0; k < 60 && cap_q.size() < 1; k++) begin @(negedge CLK); #1; end
    DREQ = 4'h0;
    run(4);
    chk("cfg wins new addr", capv(0), 32'h5000);

    // Reset in the middle of S3 releases the bus at once and masks every channel.
    prog(2'd0, 2'b01, 16'h6000, 16'd4);
    clr(); grant = 4'b0001; DREQ = 4'b0001;
    for (int k = 0; k < 60 && MEMW_N; k++) begin @(negedge CLK); #1; end
    chk("ch0 S3 before reset", 32'(MEMW_N), 32'd0);
    RESET = 1'b1;
    #1;
    chk("reset mid strobes", 32'({MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT}), 32'h1F);
    chk("reset mid HRQ/AEN", 32'({HRQ, AEN, assertDACK}), 32'h0);
    chk("reset mid ADDR", 32'(ADDR), 32'h0);
    chk("reset mid tcStatus", 32'(tcStatus), 32'h0);
    @(posedge CLK); #2;
    RESET = 1'b0;
    clr(); DREQ = 4'hF;
    run(12);
    chk("post reset no HRQ", 32'(hrq_cnt), 32'd0);
    prog(2'd0, 2'b01, 16'h6000, 16'd4);
    clr();
    for (int k = 0; k < 60 && cap_q.size() < 1; k++) begin @(negedge CLK); #1; end
    DREQ = 4'h0;
    run(4);
    chk("reprogram addr", capv(0), 32'h6000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
